// File: rtl/csr_access_unit.sv
// csr_access_unit: sequences one Zicsr instruction (CSRRW/RS/RC and the
// immediate forms) against csregfile in three cycles: IDLE -> READ -> WRITE.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only in IDLE)
//   req_op, req_imm          operation (01 RW, 10 RS, 11 RC, 00 illegal), source select
//   req_rs1_idx/_data        rs1 index (x0 rule only) and value
//   req_zimm, req_csr_addr   immediate source, target CSR
//   req_rd                   destination GPR
//   csr_raddr / csr_rdata    csregfile read port (read data is combinational)
//   csr_waddr / csr_wdata    csregfile CSR write port (MDISABLE = no write)
//   rd_waddr / rd_wdata      GPR write-back (ZERO_REG = no write)
//   done, illegal            one-cycle pulses in the WRITE cycle
module csr_access_unit #(
    parameter bit          RO_CHECK = 1'b1,
    parameter logic [11:0] MDISABLE = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic        req_imm,
    input  logic [4:0]  req_rs1_idx,
    input  logic [31:0] req_rs1_data,
    input  logic [4:0]  req_zimm,
    input  logic [11:0] req_csr_addr,
    input  logic [4:0]  req_rd,
    output logic [11:0] csr_raddr,
    input  logic [31:0] csr_rdata,
    output logic [11:0] csr_waddr,
    output logic [31:0] csr_wdata,
    output logic [4:0]  rd_waddr,
    output logic [31:0] rd_wdata,
    output logic        done,
    output logic        illegal
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CSR_AW = 12;
    localparam int unsigned REG_AW = 5;

    localparam logic [REG_AW-1:0] ZERO_REG = REG_AW'(0);

    localparam logic [1:0] OP_ILL = 2'b00;
    localparam logic [1:0] OP_RW  = 2'b01;
    localparam logic [1:0] OP_RS  = 2'b10;
    localparam logic [1:0] OP_RC  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched request fields
    logic [1:0]        op_q, op_d;
    logic              imm_q, imm_d;
    logic [REG_AW-1:0] rs1_idx_q, rs1_idx_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
    logic [REG_AW-1:0] zimm_q, zimm_d;
    logic [CSR_AW-1:0] addr_q, addr_d;
    logic [REG_AW-1:0] rd_q, rd_d;

    // Next values of the registered outputs
    logic              req_ready_d;
    logic [CSR_AW-1:0] csr_raddr_d;
    logic [CSR_AW-1:0] csr_waddr_d;
    logic [XLEN-1:0]   csr_wdata_d;
    logic [REG_AW-1:0] rd_waddr_d;
    logic [XLEN-1:0]   rd_wdata_d;
    logic              done_d;
    logic              illegal_d;

    // Datapath decoded from latched fields and the read data
    logic [XLEN-1:0] src_c;
    logic [XLEN-1:0] new_val_c;
    logic            wr_intent_c;
    logic            illegal_c;

    always_comb begin
        src_c = imm_q ? XLEN'(zimm_q) : rs1_data_q;

        unique case (op_q)
            OP_RS:   new_val_c = csr_rdata | src_c;
            OP_RC:   new_val_c = csr_rdata & ~src_c;
            default: new_val_c = src_c;
        endcase

        // Set/clear write only for a nonzero-encoded source (index/zimm, not data)
        wr_intent_c = (op_q == OP_RW) || (imm_q ? (zimm_q != ZERO_REG) : (rs1_idx_q != ZERO_REG));

        illegal_c = (op_q == OP_ILL) ||
                    (RO_CHECK && wr_intent_c && (addr_q[11:10] == 2'b11));
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        imm_d       = imm_q;
        rs1_idx_d   = rs1_idx_q;
        rs1_data_d  = rs1_data_q;
        zimm_d      = zimm_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        req_ready_d = 1'b0;
        csr_raddr_d = CSR_AW'(0);
        csr_waddr_d = MDISABLE;
        csr_wdata_d = XLEN'(0);
        rd_waddr_d  = ZERO_REG;
        rd_wdata_d  = XLEN'(0);
        done_d      = 1'b0;
        illegal_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d        = req_op;
                    imm_d       = req_imm;
                    rs1_idx_d   = req_rs1_idx;
                    rs1_data_d  = req_rs1_data;
                    zimm_d      = req_zimm;
                    addr_d      = req_csr_addr;
                    rd_d        = req_rd;
                    csr_raddr_d = req_csr_addr;
                    state_d     = READ;
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            READ: begin
                // Old value is captured here straight into the write-back register
                csr_raddr_d = addr_q;
                done_d      = 1'b1;
                state_d     = WRITE;
                if (illegal_c) begin
                    illegal_d = 1'b1;
                end else begin
                    rd_waddr_d = rd_q;
                    rd_wdata_d = csr_rdata;
                    if (wr_intent_c) begin
                        csr_waddr_d = addr_q;
                        csr_wdata_d = new_val_c;
                    end
                end
            end
            WRITE: begin
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State, latched fields and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= OP_ILL;
            imm_q      <= 1'b0;
            rs1_idx_q  <= ZERO_REG;
            rs1_data_q <= XLEN'(0);
            zimm_q     <= ZERO_REG;
            addr_q     <= CSR_AW'(0);
            rd_q       <= ZERO_REG;
            req_ready  <= 1'b1;
            csr_raddr  <= CSR_AW'(0);
            csr_waddr  <= MDISABLE;
            csr_wdata  <= XLEN'(0);
            rd_waddr   <= ZERO_REG;
            rd_wdata   <= XLEN'(0);
            done       <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            imm_q      <= imm_d;
            rs1_idx_q  <= rs1_idx_d;
            rs1_data_q <= rs1_data_d;
            zimm_q     <= zimm_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            req_ready  <= req_ready_d;
            csr_raddr  <= csr_raddr_d;
            csr_waddr  <= csr_waddr_d;
            csr_wdata  <= csr_wdata_d;
            rd_waddr   <= rd_waddr_d;
            rd_wdata   <= rd_wdata_d;
            done       <= done_d;
            illegal    <= illegal_d;
        end
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: directed bench with a small csregfile model
// (mstatus, mepc, mvendorid) committing CSR writes on the rising edge.
module tb_csr_access_unit;

    localparam logic [11:0] MDISABLE  = 12'h000;
    localparam logic [11:0] MSTATUS   = 12'h300;
    localparam logic [11:0] MEPC      = 12'h341;
    localparam logic [11:0] MVENDORID = 12'hF11;
    localparam logic [31:0] VENDOR_ID = 32'h0000_0489;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic        req_imm;
    logic [4:0]  req_rs1_idx;
    logic [31:0] req_rs1_data;
    logic [4:0]  req_zimm;
    logic [11:0] req_csr_addr;
    logic [4:0]  req_rd;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [4:0]  rd_waddr;
    logic [31:0] rd_wdata;
    logic        done;
    logic        illegal;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    csr_access_unit #(.RO_CHECK(1'b1), .MDISABLE(MDISABLE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_imm(req_imm),
        .req_rs1_idx(req_rs1_idx), .req_rs1_data(req_rs1_data),
        .req_zimm(req_zimm), .req_csr_addr(req_csr_addr), .req_rd(req_rd),
        .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
        .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // csregfile model
    logic        init;
    logic [31:0] m_mstatus, m_mepc;

    always @(posedge clk) begin
        if (init) begin
            m_mstatus <= 32'h0000_00AA;
            m_mepc    <= 32'h0;
        end else if (!rst && csr_waddr != MDISABLE) begin
            if (csr_waddr == MSTATUS) m_mstatus <= csr_wdata;
            if (csr_waddr == MEPC)    m_mepc    <= csr_wdata;
        end
    end

    always_comb begin
        csr_rdata = 32'h0;
        if (csr_raddr == MSTATUS)   csr_rdata = m_mstatus;
        if (csr_raddr == MEPC)      csr_rdata = m_mepc;
        if (csr_raddr == MVENDORID) csr_rdata = VENDOR_ID;
    end

    typedef struct {
        logic [1:0]  op;
        logic        imm;
        logic [4:0]  rs1_idx;
        logic [31:0] rs1_data;
        logic [4:0]  zimm;
        logic [11:0] addr;
        logic [4:0]  rd;
        logic [11:0] e_waddr;
        logic [31:0] e_wdata;
        logic [4:0]  e_rd;
        logic [31:0] e_rdw;
        logic        e_ill;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait (bounded) at a negedge for req_ready, then present the request
    task automatic present(input logic [1:0] op, input logic imm, input logic [4:0] rs1_idx,
                           input logic [31:0] rs1_data, input logic [4:0] zimm,
                           input logic [11:0] addr, input logic [4:0] rd);
        bit seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (req_ready) seen = 1'b1;
        end
        chk("ready_wait", 32'(seen), 32'd1);
        req_op = op; req_imm = imm; req_rs1_idx = rs1_idx; req_rs1_data = rs1_data;
        req_zimm = zimm; req_csr_addr = addr; req_rd = rd;
        req_valid = 1'b1;
    endtask

    // Accept at next edge, then stop at the negedge of the WRITE cycle
    task automatic run_to_write();
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("read_ready", 32'(req_ready), 32'd0);
        chk("read_done", 32'(done), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int t0, t1;
        bit got;
        rst = 1'b1; init = 1'b1; req_valid = 1'b0;
        req_op = 2'b00; req_imm = 1'b0; req_rs1_idx = 5'd0; req_rs1_data = 32'h0;
        req_zimm = 5'd0; req_csr_addr = 12'h0; req_rd = 5'd0;

        //                op    imm rs1 data          zimm   addr       rd     waddr     wdata         rd     rdw        ill
        vecs[0]  = '{2'b01, 1'b0, 5'd3, 32'h0000_00C3, 5'h00, MEPC,      5'd4,  MEPC,     32'h0000_00C3, 5'd4,  32'h0,     1'b0};
        vecs[1]  = '{2'b01, 1'b0, 5'd3, 32'h0000_0055, 5'h00, MEPC,      5'd6,  MEPC,     32'h0000_0055, 5'd6,  32'h00C3,  1'b0};
        vecs[2]  = '{2'b10, 1'b1, 5'd0, 32'h0,         5'h05, MSTATUS,   5'd7,  MSTATUS,  32'h0000_00AF, 5'd7,  32'h00AA,  1'b0};
        vecs[3]  = '{2'b11, 1'b0, 5'd8, 32'h0000_000F, 5'h00, MSTATUS,   5'd9,  MSTATUS,  32'h0000_00A0, 5'd9,  32'h00AF,  1'b0};
        vecs[4]  = '{2'b10, 1'b0, 5'd0, 32'h0000_FFFF, 5'h00, MSTATUS,   5'd10, MDISABLE, 32'h0,         5'd10, 32'h00A0,  1'b0};
        vecs[5]  = '{2'b10, 1'b0, 5'd5, 32'h0,         5'h00, MSTATUS,   5'd11, MSTATUS,  32'h0000_00A0, 5'd11, 32'h00A0,  1'b0};
        vecs[6]  = '{2'b01, 1'b0, 5'd3, 32'h0000_0001, 5'h00, MVENDORID, 5'd12, MDISABLE, 32'h0,         5'd0,  32'h0,     1'b1};
        vecs[7]  = '{2'b10, 1'b1, 5'd0, 32'h0,         5'h00, MVENDORID, 5'd13, MDISABLE, 32'h0,         5'd13, VENDOR_ID, 1'b0};
        vecs[8]  = '{2'b00, 1'b0, 5'd3, 32'h0000_0077, 5'h00, MEPC,      5'd14, MDISABLE, 32'h0,         5'd0,  32'h0,     1'b1};
        vecs[9]  = '{2'b11, 1'b1, 5'd0, 32'h0,         5'h11, MEPC,      5'd0,  MEPC,     32'h0000_0044, 5'd0,  32'h0055,  1'b0};
        vecs[10] = '{2'b01, 1'b1, 5'd0, 32'h0,         5'h1F, MSTATUS,   5'd1,  MSTATUS,  32'h0000_001F, 5'd1,  32'h00A0,  1'b0};
        vecs[11] = '{2'b11, 1'b0, 5'd0, 32'hFFFF_FFFF, 5'h00, MVENDORID, 5'd15, MDISABLE, 32'h0,         5'd15, VENDOR_ID, 1'b0};

        // Reset values
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_raddr", 32'(csr_raddr), 32'(12'h0));
        chk("rst_waddr", 32'(csr_waddr), 32'(MDISABLE));
        chk("rst_wdata", csr_wdata, 32'h0);
        chk("rst_rd_waddr", 32'(rd_waddr), 32'd0);
        chk("rst_rd_wdata", rd_wdata, 32'h0);
        rst = 1'b0; init = 1'b0;

        // Table-driven single instructions
        foreach (vecs[i]) begin
            present(vecs[i].op, vecs[i].imm, vecs[i].rs1_idx, vecs[i].rs1_data,
                    vecs[i].zimm, vecs[i].addr, vecs[i].rd);
            run_to_write();
            chk($sformatf("v%0d_done", i), 32'(done), 32'd1);
            chk($sformatf("v%0d_illegal", i), 32'(illegal), 32'(vecs[i].e_ill));
            chk($sformatf("v%0d_raddr", i), 32'(csr_raddr), 32'(vecs[i].addr));
            chk($sformatf("v%0d_waddr", i), 32'(csr_waddr), 32'(vecs[i].e_waddr));
            chk($sformatf("v%0d_wdata", i), csr_wdata, vecs[i].e_wdata);
            chk($sformatf("v%0d_rd_waddr", i), 32'(rd_waddr), 32'(vecs[i].e_rd));
            chk($sformatf("v%0d_rd_wdata", i), rd_wdata, vecs[i].e_rdw);
            @(negedge clk);
            chk($sformatf("v%0d_post_done", i), 32'(done), 32'd0);
            chk($sformatf("v%0d_post_ready", i), 32'(req_ready), 32'd1);
            chk($sformatf("v%0d_post_waddr", i), 32'(csr_waddr), 32'(MDISABLE));
        end

        // Reset held for 2 cycles mid-WRITE aborts the write (mepc stays 0x44)
        present(2'b01, 1'b0, 5'd3, 32'h0000_DEAD, 5'd0, MEPC, 5'd5);
        run_to_write();
        chk("abort_pre_waddr", 32'(csr_waddr), 32'(MEPC));
        rst = 1'b1;
        @(negedge clk);
        chk("abort_waddr", 32'(csr_waddr), 32'(MDISABLE));
        chk("abort_rd_waddr", 32'(rd_waddr), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        present(2'b10, 1'b0, 5'd0, 32'h0, 5'd0, MEPC, 5'd2);
        run_to_write();
        chk("abort_mepc_kept", rd_wdata, 32'h0000_0044);

        // Back-to-back: request held valid continuously
        present(2'b01, 1'b0, 5'd3, 32'h0000_1234, 5'd0, MEPC, 5'd2);
        @(posedge clk);
        #1 t0 = cyc;
        req_op = 2'b10; req_rs1_idx = 5'd0; req_rs1_data = 32'h0; req_rd = 5'd3;
        got = 1'b0; t1 = t0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (i == 1) chk("b2b_first_wdata", csr_wdata, 32'h0000_1234);
            if (req_ready) begin
                @(posedge clk);
                #1 t1 = cyc;
                got = 1'b1;
            end
        end
        req_valid = 1'b0;
        chk("b2b_accepted", 32'(got), 32'd1);
        chk("b2b_spacing", 32'(t1 - t0), 32'd3);
        @(negedge clk);
        @(negedge clk);
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_rd_waddr", 32'(rd_waddr), 32'd3);
        chk("b2b_rd_wdata", rd_wdata, 32'h0000_1234);
        chk("b2b_waddr", 32'(csr_waddr), 32'(MDISABLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
